// File: rtl/npu_pkg.sv
// Shared definitions for the NPU stream feeder: layer-count codes, frame
// geometry constants, feeder FSM states and sticky error bit positions.
package npu_pkg;

  // Hidden-layer count carried in header word 0, bits [1:0]
  typedef enum logic [1:0] {
    NlZeroHidden = 2'd0,
    NlOneHidden  = 2'd1,
    NlTwoHidden  = 2'd2
  } layers_e;

  localparam int unsigned HdrWords   = 6;
  localparam int unsigned MaxNeurons = 32;
  // Width of one neuron-count code (value n-1)
  localparam int unsigned NnW        = $clog2(MaxNeurons);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StWgt,
    StInp,
    StWait,
    StRead,
    StDrain
  } feeder_state_e;

  localparam int unsigned ErrUnderrun  = 0;
  localparam int unsigned ErrIllegalNl = 1;

endpackage

// File: rtl/npu_result_fifo.sv
// Synchronous result FIFO holding {last, data} entries.
// Ports: clk/rst (async active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o shows the head entry), full_o/empty_o.
module npu_result_fifo #(
  parameter int unsigned OFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [32:0] wdata_i,
  input  logic        pop_i,
  output logic [32:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW = $clog2(OFIFO_DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [32:0]   mem_q [OFIFO_DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/npu_stream_feeder.sv
// Host-side front end of the NPU array controller. Forwards one frame
// (header, weights/biases, input vector) from the s_* stream onto the NPU
// bus with npu_we, waits for npu_ready, reads results with npu_oe into a
// small FIFO and presents them on the m_* stream with a last marker.
// Ports: clk/rst (async active-high); s_valid/s_data/s_ready host input;
// npu_we/npu_wdata/npu_wdata_en/npu_rdata/npu_ready/npu_oe NPU bus;
// m_valid/m_data/m_last/m_ready result output; busy, err status.
module npu_stream_feeder
  import npu_pkg::*;
#(
  parameter int unsigned OFIFO_DEPTH = 4,
  parameter int unsigned CNT_W       = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        npu_we,
  output logic [31:0] npu_wdata,
  output logic        npu_wdata_en,
  input  logic [31:0] npu_rdata,
  input  logic        npu_ready,
  output logic        npu_oe,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic [1:0]  err
);

  feeder_state_e           state_q, state_d;
  logic                    en_q;  // holds s_ready low until the first edge out of reset
  logic                    npu_we_q;
  logic [31:0]             npu_wdata_q;
  logic [1:0]              nl_q, nl_d;
  logic [1:0]              err_q, err_d;
  logic [3:0][NnW-1:0]     nn_q, nn_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NnW:0]            k_q, k_d;
  logic [NnW-1:0]          j_q, j_d;
  logic [1:0]              lyr_q, lyr_d;

  logic                    xfer, underrun, push, push_last;
  logic                    fifo_full, fifo_empty;
  logic [32:0]             fifo_rdata;
  logic [NnW-1:0]          in_code, out_code;
  logic                    last_k;

  assign xfer      = s_valid && s_ready;
  assign underrun  = !s_valid && (state_q inside {StHdr, StWgt, StInp});
  assign push      = npu_oe;
  assign push_last = (cnt_q == CNT_W'(nn_q[3]));

  // The output layer (lyr == num_layers) reads its width from nn[3]
  assign in_code  = nn_q[lyr_q];
  assign out_code = (lyr_q == nl_q) ? nn_q[3] : nn_q[lyr_q + 2'd1];
  assign last_k   = (k_q == {1'b0, in_code} + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    nl_d    = nl_q;
    err_d   = err_q;
    nn_d    = nn_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    j_d     = j_q;
    lyr_d   = lyr_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          nl_d  = (s_data[1:0] == 2'd3) ? 2'(NlTwoHidden) : s_data[1:0];
          err_d = '0;
          err_d[ErrIllegalNl] = (s_data[1:0] == 2'd3);
          cnt_d   = CNT_W'(1);
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (xfer) begin
          if (cnt_q == CNT_W'(HdrWords - 1)) begin
            // do_act word: forwarded only
            cnt_d   = '0;
            k_d     = '0;
            j_d     = '0;
            lyr_d   = '0;
            state_d = StWgt;
          end else begin
            nn_d[2'(cnt_q - CNT_W'(1))] = s_data[NnW-1:0];
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWgt: begin
        if (xfer) begin
          if (last_k) begin
            k_d = '0;
            if (j_q == out_code) begin
              j_d = '0;
              if (lyr_q == nl_q) begin
                cnt_d   = '0;
                state_d = StInp;
              end else begin
                lyr_d = lyr_q + 1'b1;
              end
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StInp: begin
        if (xfer) begin
          if (cnt_q == CNT_W'(nn_q[0])) begin
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWait: begin
        if (npu_ready) state_d = StRead;
      end
      StRead: begin
        if (push) begin
          if (push_last) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (underrun) err_d[ErrUnderrun] = 1'b1;
  end

  always_comb begin
    s_ready = 1'b0;
    npu_oe  = 1'b0;
    unique case (state_q)
      StIdle, StHdr, StWgt, StInp: s_ready = en_q;
      StRead:                      npu_oe  = npu_ready && !fifo_full;
      default:                     ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q        <= 1'b0;
      npu_we_q    <= 1'b0;
      npu_wdata_q <= '0;
      nl_q        <= '0;
      err_q       <= '0;
      nn_q        <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      j_q         <= '0;
      lyr_q       <= '0;
    end else begin
      en_q     <= 1'b1;
      npu_we_q <= xfer;
      if (xfer) npu_wdata_q <= s_data;
      nl_q     <= nl_d;
      err_q    <= err_d;
      nn_q     <= nn_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      j_q      <= j_d;
      lyr_q    <= lyr_d;
    end
  end

  npu_result_fifo #(
    .OFIFO_DEPTH(OFIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({push_last, npu_rdata}),
    .pop_i   (m_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign npu_we       = npu_we_q;
  assign npu_wdata    = npu_wdata_q;
  assign npu_wdata_en = npu_we_q;
  assign m_valid      = !fifo_empty;
  assign m_data       = fifo_rdata[31:0];
  assign m_last       = !fifo_empty && fifo_rdata[32];
  assign busy         = (state_q != StIdle);
  assign err          = err_q;

endmodule

// File: tb/tb_npu_stream_feeder.sv
module tb_npu_stream_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        npu_we, npu_wdata_en, npu_ready, npu_oe;
  logic [31:0] npu_wdata, npu_rdata;
  logic        m_valid, m_last, m_ready, busy;
  logic [31:0] m_data;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  // NPU result source: presents the next pool word after every read strobe
  logic [31:0] pool [256];
  int          oe_total = 0;
  logic        oe_seen  = 1'b0;
  logic        prev_we  = 1'b0;
  int          we_rise  = 0;
  logic [31:0] we_q [$];
  logic [32:0] got_q [$];

  logic [31:0] tx_q [$];
  int          exp_nres;
  int          we_base, rise_base;

  always #5 clk = ~clk;

  assign npu_rdata = pool[oe_total[7:0]];

  always @(negedge clk) begin
    oe_seen <= npu_oe;
    prev_we <= npu_we;
    if (npu_we) we_q.push_back(npu_wdata);
    if (npu_we && !prev_we) we_rise <= we_rise + 1;
    if (m_valid && m_ready) got_q.push_back({m_last, m_data});
  end

  always @(posedge clk) if (oe_seen) oe_total <= oe_total + 1;

  npu_stream_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .npu_we       (npu_we),
    .npu_wdata    (npu_wdata),
    .npu_wdata_en (npu_wdata_en),
    .npu_rdata    (npu_rdata),
    .npu_ready    (npu_ready),
    .npu_oe       (npu_oe),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .busy         (busy),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame words from the layer rules: per layer (in+2)*(out+1) weight words
  task automatic build_frame(input logic [1:0] hl, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [4:0] d);
    logic [4:0]  nn [4];
    logic [31:0] w;
    int          nl, nw;
    nn[0] = a; nn[1] = b; nn[2] = c; nn[3] = d;
    nl = (hl == 2'd3) ? 2 : int'(hl);
    nw = 0;
    for (int l = 0; l <= nl; l++) begin
      int ic = int'(nn[l]);
      int oc = (l == nl) ? int'(nn[3]) : int'(nn[l + 1]);
      nw += (ic + 2) * (oc + 1);
    end
    tx_q.delete();
    w = $urandom; w[1:0] = hl; tx_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      w = $urandom; w[4:0] = nn[i]; tx_q.push_back(w);
    end
    tx_q.push_back($urandom);
    for (int i = 0; i < nw + int'(nn[0]) + 1; i++) tx_q.push_back($urandom);
    exp_nres = int'(nn[3]) + 1;
  endtask

  task automatic send_frame(input int gap_at, input int gap_len, input int stop_after);
    we_base   = we_q.size();
    rise_base = we_rise;
    for (int i = 0; i < tx_q.size() && i < stop_after; i++) begin
      if (i == gap_at) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          chk("underrun_we_low", npu_we, 0);
        end
      end
      s_valid = 1'b1;
      s_data  = tx_q[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic frame_done(input logic [1:0] exp_err, input bit gapless);
    int nbad = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("we_count", we_q.size() - we_base, tx_q.size());
    for (int i = 0; i < tx_q.size(); i++)
      if (we_base + i >= we_q.size() || we_q[we_base + i] !== tx_q[i]) nbad++;
    chk("we_data_bad_words", nbad, 0);
    if (gapless) chk("we_single_burst", we_rise - rise_base, 1);
    chk("wait_s_ready_low", s_ready, 0);
    chk("wait_busy", busy, 1);
    chk("frame_err", err, exp_err);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic read_results(input int nres, input bit bp);
    int oe0  = oe_total;
    int got0 = got_q.size();
    int nbad = 0;
    m_ready   = !bp;
    npu_ready = 1'b1;
    if (bp) begin
      repeat (12) begin @(posedge clk); #1; end
      chk("bp_oe_count", oe_total - oe0, 4);
      chk("bp_oe_low", npu_oe, 0);
      chk("bp_m_valid", m_valid, 1);
      m_ready = 1'b1;
    end
    wait_idle(400, "read_idle_timeout");
    npu_ready = 1'b0;
    chk("oe_count", oe_total - oe0, nres);
    chk("result_count", got_q.size() - got0, nres);
    for (int i = 0; i < nres; i++) begin
      logic [32:0] e;
      e = {(i == nres - 1), pool[(oe0 + i) % 256]};
      if (got0 + i >= got_q.size() || got_q[got0 + i] !== e) nbad++;
    end
    chk("result_bad_words", nbad, 0);
    chk("m_valid_after", m_valid, 0);
  endtask

  task automatic small_frame();
    build_frame(2'd0, 5'd1, 5'($urandom), 5'($urandom), 5'd0);
    chk("small_len", tx_q.size(), 11);
    send_frame(-1, 0, 1 << 30);
    frame_done(2'b00, 1'b1);
    read_results(exp_nres, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pool[i] = $urandom;
    pool[0]   = 32'h3F80_0000;
    s_valid   = 1'b0;
    s_data    = '0;
    npu_ready = 1'b0;
    m_ready   = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_npu_we", npu_we, 0);
    chk("rst_wdata_en", npu_wdata_en, 0);
    chk("rst_wdata", npu_wdata, 0);
    chk("rst_npu_oe", npu_oe, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_s_ready", s_ready, 1);

    // Smallest frame
    small_frame();

    // Max frame
    wait_idle(50, "idle_before_max");
    build_frame(2'd2, 5'd31, 5'd31, 5'd31, 5'd31);
    chk("max_len", tx_q.size(), 3206);
    send_frame(-1, 0, 1 << 30);
    frame_done(2'b00, 1'b1);
    read_results(exp_nres, 1'b0);

    // Backpressure on results
    wait_idle(50, "idle_before_bp");
    build_frame(2'd1, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom), 5'd7);
    send_frame(-1, 0, 1 << 30);
    frame_done(2'b00, 1'b1);
    read_results(exp_nres, 1'b1);

    // Underrun in the weight phase
    wait_idle(50, "idle_before_underrun");
    build_frame(2'd0, 5'd3, 5'($urandom), 5'($urandom), 5'd2);
    send_frame(8, 2, 1 << 30);
    frame_done(2'b01, 1'b0);
    chk("underrun_bursts", we_rise - rise_base, 2);
    read_results(exp_nres, 1'b0);

    // Illegal layer count behaves as two hidden layers
    wait_idle(50, "idle_before_illegal");
    build_frame(2'd3, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
    send_frame(-1, 0, 1 << 30);
    frame_done(2'b10, 1'b1);
    read_results(exp_nres, 1'b0);

    // Asynchronous reset at weight word 100
    wait_idle(50, "idle_before_reset");
    build_frame(2'd2, 5'd31, 5'd31, 5'd31, 5'd31);
    send_frame(-1, 0, 106);
    chk("pre_reset_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_npu_we", npu_we, 0);
    chk("arst_wdata_en", npu_wdata_en, 0);
    chk("arst_wdata", npu_wdata, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_npu_oe", npu_oe, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_s_ready", s_ready, 1);
    small_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_stream_feeder.md
Name: npu_stream_feeder

Overview:
- Host-side front end that sits directly upstream of the NPU array controller and owns its shared 32-bit data bus.
- Accepts one frame per inference on a valid/ready word stream and forwards it to the NPU on the write strobe `npu_we`, gapless: 6 config words, then all weights and biases, then the input vector.
- Waits for the NPU `ready` flag, then drains results with `npu_oe` into a small output FIFO.
- Presents results on a valid/ready stream with a last marker.

Parameters:
- OFIFO_DEPTH, 4, depth of the result FIFO (power of 2, ≥2).
- CNT_W, 12, width of the frame word counters (≥ log2(3*32*33)).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_valid  in  1  host word valid
- s_data  in  32  host word
- s_ready  out  1  feeder accepts word
- npu_we  out  1  NPU write strobe (registered)
- npu_wdata  out  32  word driven onto the NPU bus (registered)
- npu_wdata_en  out  1  tristate enable for npu_wdata; equals npu_we
- npu_rdata  in  32  NPU bus value during reads
- npu_ready  in  1  NPU results available
- npu_oe  out  1  NPU read strobe (combinational)
- m_valid  out  1  result valid
- m_data  out  32  result word
- m_last  out  1  last result of the frame
- m_ready  in  1  downstream accepts result
- busy  out  1  frame in progress (state != IDLE)
- err  out  2  sticky flags: [0] input underrun, [1] illegal num_layers; cleared on the next frame's first word

Behaviour:
- Reset values:
  - npu_we = 0, npu_wdata_en = 0, npu_wdata = 0, npu_oe = 0.
  - s_ready = 0 while in reset; it rises to 1 in IDLE after reset deasserts.
  - m_valid = 0, m_last = 0, busy = 0, err = 0, FIFO empty, all counters 0.
- Reset mid-frame aborts immediately to IDLE. No partial words are flushed.
- States: IDLE, HDR, WGT, INP, WAIT, READ, DRAIN.
- Forwarding to the NPU:
  - A word transfers when s_valid && s_ready.
  - Each transfer sets npu_we = 1 and npu_wdata = s_data on the next cycle (1-cycle latency). npu_we drops the cycle after a non-transfer.
  - s_ready = 1 only in IDLE, HDR, WGT, INP.
- IDLE: the first transfer is header word 0. Capture num_layers = s_data[1:0], clear err, go to HDR.
  - If num_layers == 3, set err[1] and treat it as 2.
- HDR: words 1..4 capture nn[0..3] = s_data[4:0]. Each value encodes n-1 neurons.
  - Word 5 (do_act) is forwarded only. Then go to WGT.
- WGT: nested counters k (word within neuron), j (neuron), L (layer).
  - Layer count = num_layers + 1.
  - Layer L input code: nn[L] for hidden layers; nn[num_layers] for the output layer.
  - Layer L output code: nn[L+1] for hidden layers; nn[3] for the output layer.
  - Words per neuron = in_code + 2 (weights plus bias). k runs 0..in_code+1.
  - Neurons per layer = out_code + 1.
  - No multipliers: counting is done by wrapping the counters only.
  - After the last word of the last layer, go to INP.
- INP: forward nn[0]+1 input words, then go to WAIT.
- Underrun: s_valid == 0 for any cycle in HDR, WGT or INP sets err[0].
  - The state and counters hold; the NPU is already desynchronised, so the host must re-issue after reset.
- WAIT: when npu_ready == 1, go to READ. s_ready = 0.
- READ:
  - npu_oe = npu_ready && !fifo_full.
  - On each cycle with npu_oe = 1, push npu_rdata into the FIFO at that edge, tagged last when it is read nn[3].
  - After nn[3]+1 pushes, go to DRAIN.
  - npu_ready falling early: hold the state, npu_oe = 0.
- DRAIN: when the FIFO is empty, go to IDLE.
  - A new frame may not start until the FIFO is empty. This keeps s_ready = 0 in READ/DRAIN.
- FIFO:
  - m_valid = !empty. The head word drives m_data and m_last; it pops on m_valid && m_ready.
  - A push and a pop in the same cycle are allowed. Full is evaluated before the pop, so the design is conservative.
  - The FIFO never overflows or underflows.

Decomposition:
- Package npu_pkg:
  - Layer-count codes ZERO/ONE/TWO_HIDDEN.
  - HDR_WORDS = 6, MAX_NEURONS = 32.
  - Feeder state enumeration.
  - err bit indices.
- Sub-module npu_result_fifo: synchronous FIFO, 33-bit entries (data + last), with full/empty outputs, parameterised by OFIFO_DEPTH.

Test Plan:
- Smallest frame: num_layers=0, nn=1,x,x,0, host holds s_valid=1.
  - Required: exactly 11 npu_we pulses (6 header + 3 weight + 2 input), enters WAIT.
  - Then with npu_ready=1 and npu_rdata=0x3F800000: one npu_oe; m_data=0x3F800000 with m_last=1; busy drops after the pop.
- Max frame: num_layers=2, nn=31,31,31,31.
  - Required: 6+3168+32 = 3206 consecutive npu_we pulses; 32 results; m_last only on the 32nd.
- Backpressure: nn[3]=7, m_ready=0.
  - Required: exactly 4 npu_oe pulses, then npu_oe=0 with npu_ready still 1.
  - Raising m_ready resumes; all 8 words arrive in order.
- Underrun: drop s_valid for 2 cycles in WGT.
  - Required: err=2'b01; npu_we=0 for those cycles; counters resume unchanged.
- Illegal header: header word 0 = 3.
  - Required: err[1]=1, and the weight count matches the num_layers=2 case.
- Reset at weight word 100.
  - Required: all outputs return to reset values asynchronously. A subsequent 11-word frame behaves exactly as in the first scenario.
